// File: rtl/controle_mult_div.sv
// Iterative 32x32 unsigned multiply / divide controller.
// mult: shift-add, one multiplier bit per clock; div: restoring shift-subtract,
// one quotient bit per clock. Results land on hi/lo when the 32nd iteration ends.
module controle_mult_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  alu_con,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ACC_W  = 2 * DATA_W;
    localparam int unsigned CNT_W  = 5;

    localparam logic [2:0]       OP_MULT  = 3'b010;
    localparam logic [2:0]       OP_DIV   = 3'b011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;

    logic [DATA_W:0]     mult_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [ACC_W-1:0]    acc_step;

    // One datapath iteration. The accumulator holds {upper/remainder, lower/quotient}.
    always_comb begin
        mult_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]}
                  + (acc_q[0] ? {1'b0, operand_q} : (DATA_W+1)'(0));
        div_shift = {acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, operand_q};
        div_ge    = (div_shift >= {1'b0, operand_q});
        if (is_div_q) begin
            acc_step = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                        acc_q[DATA_W-2:0], div_ge};
        end else begin
            acc_step = {mult_sum, acc_q[DATA_W-1:1]};
        end
    end

    // Next-state, operand latch and result update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start && (alu_con == OP_MULT || alu_con == OP_DIV)) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    dz_d      = 1'b0;
                    is_div_d  = (alu_con == OP_DIV);
                    operand_d = (alu_con == OP_DIV) ? op_b : op_a;
                    acc_d     = {DATA_W'(0), ((alu_con == OP_DIV) ? op_a : op_b)};
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    hi_d    = acc_step[ACC_W-1:DATA_W];
                    lo_d    = acc_step[DATA_W-1:0];
                    dz_d    = is_div_q && (operand_q == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            operand_q <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_controle_mult_div.sv
// Self-checking bench for controle_mult_div: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_controle_mult_div;

    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  alu_con;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int n_checks;
    int n_errors;

    // Reference state: what hi/lo/div_zero must currently show.
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    controle_mult_div dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_con  (alu_con),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to completion (or to a planted reset).
    task automatic run_op(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input int rst_at);
        logic [63:0] prod;
        logic [31:0] nh;
        logic [31:0] nl;
        logic        ndz;
        int          lat;
        bit          got_done;

        if (alu == OP_MULT) begin
            prod = 64'(a) * 64'(b);
            nh   = prod[63:32];
            nl   = prod[31:0];
            ndz  = 1'b0;
        end else if (b == 32'd0) begin
            nh  = a;
            nl  = 32'hFFFF_FFFF;
            ndz = 1'b1;
        end else begin
            nh  = a % b;
            nl  = a / b;
            ndz = 1'b0;
        end

        @(negedge clk);
        start   = 1'b1;
        alu_con = alu;
        op_a    = a;
        op_b    = b;
        @(negedge clk);
        start   = 1'b0;
        op_a    = $urandom;
        op_b    = $urandom;
        alu_con = 3'($urandom);
        exp_dz  = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("done_after_accept", 64'(done), 64'd0);
        check("dz_cleared_on_accept", 64'(div_zero), 64'd0);

        got_done = 0;
        lat      = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_at) begin
                start   = 1'b1;
                alu_con = OP_MULT;
                op_a    = $urandom;
                op_b    = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got_done = 1;
                lat      = k;
                break;
            end
            check("busy_in_calc", 64'(busy), 64'd1);
            check("hilo_held_in_calc", {hi, lo}, {exp_hi, exp_lo});
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                exp_hi = '0;
                exp_lo = '0;
                exp_dz = 1'b0;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_hilo", {hi, lo}, 64'd0);
                check("rst_dz", 64'(div_zero), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", 64'(done), 64'd0);
                end
                rst_n = 1'b1;
                return;
            end
        end

        check("done_seen", 64'(got_done), 64'd1);
        check("latency", 64'(lat), 64'd32);
        check("busy_at_done", 64'(busy), 64'd0);
        check("result_hi", 64'(hi), 64'(nh));
        check("result_lo", 64'(lo), 64'(nl));
        check("result_dz", 64'(div_zero), 64'(ndz));
        exp_hi = nh;
        exp_lo = nl;
        exp_dz = ndz;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("hilo_after_done", {hi, lo}, {exp_hi, exp_lo});
    endtask

    // start with a non-mult/div code must leave everything untouched.
    task automatic run_noop(input logic [2:0] alu);
        @(negedge clk);
        start   = 1'b1;
        alu_con = alu;
        op_a    = $urandom;
        op_b    = $urandom;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            check("noop_busy", 64'(busy), 64'd0);
            check("noop_done", 64'(done), 64'd0);
            check("noop_hilo", {hi, lo}, {exp_hi, exp_lo});
            check("noop_dz", 64'(div_zero), 64'(exp_dz));
        end
    endtask

    initial begin
        logic [2:0]  ralu;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_con  = 3'd0;
        op_a     = '0;
        op_b     = '0;
        exp_hi   = '0;
        exp_lo   = '0;
        exp_dz   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;

        run_op(OP_MULT, 32'd3, 32'd5, 0, 0);
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(OP_DIV, 32'd100, 32'd7, 0, 0);
        run_op(OP_MULT, $urandom, $urandom, 0, 0);
        run_op(OP_DIV, 32'h1234, 32'd0, 0, 0);
        run_noop(3'b000);
        run_op(OP_MULT, 32'd12345, 32'd678, 5, 0);
        run_op(OP_MULT, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 10);
        run_op(OP_DIV, 32'hFFFF_FFFF, 32'd10, 0, 0);

        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                sel  = $urandom_range(0, 5);
                ralu = (sel < 2) ? 3'(sel) : 3'(sel + 2);
                run_noop(ralu);
            end else begin
                ralu = (sel < 5) ? OP_MULT : OP_DIV;
                ra   = $urandom;
                rb   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                       ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
                run_op(ralu, ra, rb, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controle_mult_div.md
CONTROLE_MULT_DIV -- requirements
Module: controle_mult_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n are its only clock and reset.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one operation; sampled on the rising edge.
REQ-005 The block SHALL have port alu_con, input, 3 bits: operation code; 3'b010 is mult, 3'b011 is div, all others are no-op.
REQ-006 The block SHALL have port op_a, input, 32 bits: multiplicand or dividend, unsigned.
REQ-007 The block SHALL have port op_b, input, 32 bits: multiplier or divisor, unsigned.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress; the pipeline stall source.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port hi, output, 32 bits: product upper half, or division remainder.
REQ-011 The block SHALL have port lo, output, 32 bits: product lower half, or division quotient.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the last accepted div had op_b = 0.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE, plus a 5-bit iteration counter.
REQ-014 In IDLE, start=1 with alu_con of 010 or 011 SHALL latch op_a, op_b and the operation, clear the counter, and move to CALC on that edge.
REQ-015 In IDLE, start=1 with any other alu_con SHALL be ignored: state stays IDLE, no output changes.
REQ-016 In CALC the block SHALL perform one iteration per clock (mult: shift-add, one multiplier bit; div: restoring shift-subtract, one quotient bit), 32 iterations total.
REQ-017 Counter at 31 on a CALC edge: the block SHALL complete the final iteration, write hi/lo, and enter DONE on that same edge.
REQ-018 Latency: done SHALL rise on the 32nd rising edge after the edge that sampled start; busy SHALL be 1 from the sampling edge until that edge.
REQ-019 busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE; DONE SHALL always go to IDLE on the next edge.
REQ-020 start asserted in CALC or DONE SHALL be ignored: no re-latch, no queueing, no restart.
REQ-021 mult SHALL produce the full unsigned 64-bit product: hi is bits 63:32, lo is bits 31:0; no truncation or overflow flag.
REQ-022 div SHALL produce lo = floor(op_a/op_b) and hi = op_a mod op_b, both unsigned.
REQ-023 div with op_b = 0 SHALL still take 32 iterations and yield lo = 32'hFFFFFFFF and hi = op_a.
REQ-024 div_zero SHALL be set on DONE entry of a div with op_b = 0, and cleared when the next operation is accepted.
REQ-025 hi and lo SHALL change only on DONE entry and SHALL hold their values at all other times, including during CALC.
REQ-026 Inputs changing after the sampling edge SHALL NOT affect the result.

Reset
REQ-027 rst_n = 0 SHALL immediately force state IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0, lo 0, and all internal operand and accumulator registers 0.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-029 The bench SHALL cover: mult, op_a=3, op_b=5 -> busy for 32 edges, then done pulse of 1 cycle, hi=0, lo=15.
REQ-030 The bench SHALL cover: mult, op_a=op_b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 The bench SHALL cover: div, op_a=100, op_b=7 -> lo=14, hi=2, div_zero=0; a following mult clears nothing early, so hi/lo keep 2/14 until its DONE.
REQ-032 The bench SHALL cover: div, op_a=32'h1234, op_b=0 -> lo=32'hFFFFFFFF, hi=32'h1234, div_zero=1 until the next accepted start.
REQ-033 The bench SHALL cover: start with new operands at CALC iteration 5 -> ignored, original result returned; rst_n low at iteration 10 -> busy=0, hi=lo=0, no done.
REQ-034 The bench SHALL cover: start=1 with alu_con=3'b000 in IDLE -> busy stays 0, no done, hi/lo unchanged.
